// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (radix-2) and restoring divide on one shared datapath.
// Optional macro MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 mode_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DIVZERO = 3'd1,
        ST_CALC    = 3'd2,
        ST_FIX     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t               state_r, state_s;
    logic                 mode_r, neg_res_r, neg_rem_r;
    logic [WIDTH-1:0]     hi_r, lo_r, opb_r;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 ready_r, busy_r;

    logic [WIDTH-1:0]     mag1_s, mag2_s;
    logic [WIDTH:0]       mul_sum_s, div_part_s, div_diff_s;
    logic [WIDTH-1:0]     iter_hi_s, iter_lo_s;
    logic                 last_iter_s;
    logic [2*WIDTH-1:0]   prod_mag_s, fix_result_s;
    logic                 start_ok_s, div_zero_s;

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            return {WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    // Operand magnitudes, one shared iteration step, end-of-loop detect and sign fix-up.
    always_comb begin
        start_ok_s = start_i & ~annul_i;
        div_zero_s = mode_i & (opdata2_i == {WIDTH{1'b0}});
        mag1_s     = cond_negate(opdata1_i, signed_i & opdata1_i[WIDTH-1]);
        mag2_s     = cond_negate(opdata2_i, signed_i & opdata2_i[WIDTH-1]);

        mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        div_part_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s = div_part_s - {1'b0, opb_r};

        if (!mode_r) begin
            iter_hi_s = mul_sum_s[WIDTH:1];
            iter_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end else if (!div_diff_s[WIDTH]) begin
            iter_hi_s = div_diff_s[WIDTH-1:0];
            iter_lo_s = {lo_r[WIDTH-2:0], 1'b1};
        end else begin
            iter_hi_s = div_part_s[WIDTH-1:0];
            iter_lo_s = {lo_r[WIDTH-2:0], 1'b0};
        end

`ifdef MULDIV_EARLY_OUT_EN
        // Low bits of lo_r still hold unconsumed multiplier bits; once they are zero,
        // the rest of the loop would only shift, so FIX applies the outstanding shift.
        last_iter_s = (cnt_r == CW'(WIDTH - 1)) |
                      (~mode_r & ((iter_lo_s & ({WIDTH{1'b1}} >> (cnt_r + CW'(1)))) == {WIDTH{1'b0}}));
        prod_mag_s  = {hi_r, lo_r} >> (CW'(WIDTH) - cnt_r);
`else
        last_iter_s = (cnt_r == CW'(WIDTH - 1));
        prod_mag_s  = {hi_r, lo_r};
`endif

        if (!mode_r) begin
            fix_result_s = neg_res_r ? ({(2*WIDTH){1'b0}} - prod_mag_s) : prod_mag_s;
        end else begin
            fix_result_s = {cond_negate(hi_r, neg_rem_r), cond_negate(lo_r, neg_res_r)};
        end
    end

    // Next-state logic; annul overrides every non-idle transition.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_s = div_zero_s ? ST_DIVZERO : ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DIVZERO: state_s = annul_i ? ST_IDLE : ST_DONE;
            ST_CALC: begin
                if (annul_i) begin
                    state_s = ST_IDLE;
                end else if (last_iter_s) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX:  state_s = annul_i ? ST_IDLE : ST_DONE;
            ST_DONE: state_s = (annul_i || !start_i) ? ST_IDLE : ST_DONE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register with registered status decodes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == ST_DONE);
            busy_r  <= (state_s == ST_DIVZERO) || (state_s == ST_CALC) || (state_s == ST_FIX);
        end
    end

    // Operand capture and iteration datapath; divide-by-zero parks the raw dividend in hi_r.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r    <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            opb_r     <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
        end else if (state_r == ST_IDLE && start_ok_s) begin
            mode_r    <= mode_i;
            neg_res_r <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_r <= signed_i & opdata1_i[WIDTH-1];
            hi_r      <= div_zero_s ? opdata1_i : {WIDTH{1'b0}};
            lo_r      <= mode_i ? mag1_s : mag2_s;
            opb_r     <= mode_i ? mag2_s : mag1_s;
            cnt_r     <= {CW{1'b0}};
        end else if (state_r == ST_CALC && !annul_i) begin
            hi_r      <= iter_hi_s;
            lo_r      <= iter_lo_s;
            cnt_r     <= cnt_r + CW'(1);
        end
    end

    // Result register: cleared on annul, loaded in FIX or DIVZERO, otherwise held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_r <= {(2*WIDTH){1'b0}};
        end else if (state_r != ST_IDLE && annul_i) begin
            result_r <= {(2*WIDTH){1'b0}};
        end else if (state_r == ST_FIX) begin
            result_r <= fix_result_s;
        end else if (state_r == ST_DIVZERO) begin
            result_r <= {hi_r, {WIDTH{1'b1}}};
        end
    end

    assign result_o = result_r;
    assign ready_o  = ready_r;
    assign busy_o   = busy_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: latency/result model plus directed and random operations.
module tb_muldiv_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0, annul_i = 1'b0, mode_i = 1'b0, signed_i = 1'b0;
    logic [W-1:0]  opdata1_i = '0, opdata2_i = '0;
    logic [2*W-1:0] result_o;
    logic          ready_o, busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
        .mode_i(mode_i), .signed_i(signed_i), .opdata1_i(opdata1_i),
        .opdata2_i(opdata2_i), .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Reference arithmetic result for one operation.
    function automatic logic [63:0] exp_result(input logic m, input logic s,
                                               input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (!m) begin
            q = sa * sb;
            return q;
        end
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Number of edges from the sampling edge until ready_o is high.
    function automatic int exp_lat(input logic m, input logic s,
                                   input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mb;
        int hb;
        if (m && b == 32'd0) return 1;
        if (m) return W + 1;
`ifdef MULDIV_EARLY_OUT_EN
        mb = (s && b[31]) ? (32'd0 - b) : b;
        hb = 0;
        for (int i = 0; i < W; i++) if (mb[i]) hb = i;
        return (mb == 32'd0) ? 2 : hb + 2;
`else
        mb = a;
        hb = 0;
        return W + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: idle / busy countdown / ready-held.
    logic        m_busy, m_ready;
    logic [63:0] m_res, m_pend;
    int          m_left;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_res <= '0; m_pend <= '0; m_left <= 0;
        end else if ((m_busy || m_ready) && annul_i) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_res <= '0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0; m_ready <= 1'b1; m_res <= m_pend;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (m_ready) begin
            if (!start_i) m_ready <= 1'b0;
        end else if (start_i && !annul_i) begin
            m_busy <= 1'b1;
            m_left <= exp_lat(mode_i, signed_i, opdata1_i, opdata2_i);
            m_pend <= exp_result(mode_i, signed_i, opdata1_i, opdata2_i);
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("ready_o", {63'd0, ready_o}, {63'd0, m_ready});
        check("busy_o", {63'd0, busy_o}, {63'd0, m_busy});
        check("result_o", result_o, m_res);
    end

    // Runs one operation; called #1 after a rising edge. lat = -1 if annulled.
    task automatic do_op(input logic m, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input int annul_at, output int lat);
        mode_i = m; signed_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!ready_o && lat < 200) begin
            mode_i = $urandom_range(0, 1); signed_i = $urandom_range(0, 1);
            opdata1_i = $urandom; opdata2_i = $urandom;
            if (annul_at != 0 && lat == annul_at - 1) annul_i = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (annul_i) begin
                annul_i = 1'b0; start_i = 1'b0; lat = -1;
                return;
            end
        end
        if (lat >= 200) check("ready_timeout", 64'(lat), 64'd0);
        repeat (2) @(posedge clk);
        #1 start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    int lat;
    int exp_mul_lat;

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result_o, 64'd0);
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_busy", {63'd0, busy_o}, 64'd0);
        rst = 1'b1;

        check("model_div", exp_result(1'b1, 1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        check("model_smul", exp_result(1'b0, 1'b1, 32'hFFFFFFFD, 32'd5), 64'hFFFFFFFF_FFFFFFF1);

        do_op(1'b1, 1'b0, 32'd100, 32'd7, 0, lat);
        check("udiv_result", result_o, 64'h00000002_0000000E);
        check("udiv_latency", 64'(lat), 64'd33);

        do_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 0, lat);
        check("sdiv_result", result_o, 64'hFFFFFFFF_FFFFFFFD);

        do_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, lat);
        check("sdiv_overflow", result_o, 64'h00000000_80000000);

        do_op(1'b1, 1'b0, 32'h00001234, 32'd0, 0, lat);
        check("divzero_result", result_o, 64'h00001234_FFFFFFFF);
        check("divzero_latency", 64'(lat), 64'd1);

`ifdef MULDIV_EARLY_OUT_EN
        exp_mul_lat = 4;
`else
        exp_mul_lat = 33;
`endif
        do_op(1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, 0, lat);
        check("smul_result", result_o, 64'hFFFFFFFF_FFFFFFF1);
        check("smul_latency", 64'(lat), 64'(exp_mul_lat));

        do_op(1'b1, 1'b0, 32'd1000, 32'd3, 10, lat);
        check("annul_flag", 64'(lat), 64'hFFFFFFFF_FFFFFFFF);
        check("annul_result", result_o, 64'd0);
        check("annul_ready", {63'd0, ready_o}, 64'd0);

        do_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat);
        check("umul_max", result_o, 64'hFFFFFFFE_00000001);
        check("umul_max_latency", 64'(lat), 64'd33);

        // start together with annul in idle is ignored
        start_i = 1'b1; annul_i = 1'b1; mode_i = 1'b0;
        @(posedge clk); #1;
        check("idle_annul_busy", {63'd0, busy_o}, 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        @(posedge clk); #1;

        // reset in the middle of a calculation
        mode_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midreset_result", result_o, 64'd0);
        check("midreset_busy", {63'd0, busy_o}, 64'd0);
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
        exp_mul_lat = 4;
`else
        exp_mul_lat = 33;
`endif
        do_op(1'b0, 1'b0, 32'd7, 32'd6, 0, lat);
        check("post_reset_mul", result_o, 64'd42);
        check("post_reset_latency", 64'(lat), 64'(exp_mul_lat));

        for (int i = 0; i < 150; i++) begin
            logic        rm, rs;
            logic [31:0] ra, rb;
            int          an;
            rm = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ra = pick_op();
            rb = pick_op();
            an = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 30)) : 0;
            do_op(rm, rs, ra, rb, an, lat);
            if (lat > 0) check("rand_result", result_o, exp_result(rm, rs, ra, rb));
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the execute stage of the pipelined core, succeeding the fixed 32-bit divider. It performs signed or unsigned radix-2 multiplication and restoring division on WIDTH-bit operands in a single shared datapath. Operands are captured on a start handshake. The unit reports busy so the control block can stall the pipeline, and it holds a double-width result until the execute stage releases it.

## Interface
- WIDTH, 32: operand width in bits, ≥ 4; result width is 2*WIDTH.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  request; operands sampled when high in IDLE; held high until ready_o seen.
- annul_i  in  1  abort current operation.
- mode_i  in  1  0 = multiply, 1 = divide; sampled with operands.
- signed_i  in  1  1 = two's-complement operands; sampled with operands.
- opdata1_i  in  WIDTH  multiplicand / dividend.
- opdata2_i  in  WIDTH  multiplier / divisor.
- result_o  out  2*WIDTH  multiply: full product; divide: {remainder, quotient}.
- ready_o  out  1  result_o valid.
- busy_o  out  1  high in DIVZERO, CALC, FIX.

## Operation
- States: IDLE, DIVZERO, CALC, FIX, DONE.
- Reset: state IDLE, result_o = 0, ready_o = 0, busy_o = 0, all internal registers 0.
- IDLE, start_i=1, annul_i=0:
  - Capture mode and sign flags.
  - Capture operand magnitudes (negated if signed_i and MSB set).
  - Divide with opdata2_i = 0 → DIVZERO; otherwise → CALC with iteration counter 0.
- Inputs other than start_i/annul_i are ignored outside IDLE.
- CALC, multiply: if the LSB of the multiplier is 1, add the multiplicand to the upper accumulator; shift right one bit.
- CALC, divide: shift {rem, quo} left; trial subtract the divisor; if no borrow, keep the difference and set quo LSB.
- CALC: one iteration per cycle; after WIDTH iterations → FIX.
- FIX: apply sign correction and load result_o, then → DONE.
  - Product: negated if operand signs differ.
  - Quotient: negated if signs differ.
  - Remainder: takes the dividend's sign.
- Signed overflow (most-negative / −1): quotient = most-negative, remainder = 0; falls out of the algorithm with no special case.
- DIVZERO: result_o = {opdata1_i as captured (unmodified), all-ones quotient} → DONE.
- DONE: ready_o = 1 and result_o held while start_i = 1; start_i = 0 → IDLE with ready_o = 0 next edge; result_o retains its value.
- annul_i = 1 in any non-IDLE state → IDLE next edge with ready_o = 0, result_o = 0. annul_i has priority over every other transition.
- annul_i and start_i both high in IDLE: start ignored, stays IDLE.
- Reset asserted mid-operation: immediate return to reset values regardless of state.

## Timing
- Start sampled at edge k:
  - Normal: CALC iterations occur on edges k+1..k+WIDTH; FIX→DONE on edge k+WIDTH+1; ready_o high after that edge (WIDTH+1 cycles after sampling).
  - Divide-by-zero: DIVZERO on edge k, DONE on edge k+1.
- busy_o and ready_o are never high together. Both are registered state decodes with no combinational path from inputs.
- Back-to-back operation: DONE→IDLE takes one edge after start_i drops, and the next start is sampled on the following edge.

## Configuration
- MULDIV_EARLY_OUT_EN defined: in multiply mode, CALC transitions to FIX on the edge whose shift leaves the remaining multiplier bits all zero.
  - Multiply latency becomes (index of the highest set multiplier-magnitude bit + 1) + 1 cycles; a zero multiplier gives ready after edge k+2.
  - Divide is unaffected.
- Undefined: multiply always takes WIDTH iterations; the early-out comparator is absent.

## Test plan
- Unsigned divide, WIDTH=32: 100 / 7 → result_o = 0x00000002_0000000E; ready_o first high after edge k+33; busy_o high edges k..k+32.
- Signed divide: −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed overflow: 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero: 0x00001234 / 0 → result_o = 0x00001234_FFFFFFFF; ready_o high after edge k+1; result_o held until start_i drops.
- Signed multiply: −3 × 5 → 0xFFFFFFFF_FFFFFFF1. Ready after edge k+33 without the macro, or after edge k+4 with MULDIV_EARLY_OUT_EN.
- Annul: start a divide, raise annul_i at edge k+10 → IDLE, ready_o = 0, result_o = 0. A new unsigned multiply 0xFFFFFFFF × 0xFFFFFFFF then yields 0xFFFFFFFE_00000001.
- Reset: drop rst during CALC → all outputs 0 immediately. After release, the unit accepts a new start on the first rising edge.
